// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared types and helpers for the byte-serial memory sequencer.
//   op_e        request opcode encoding (6-7 decode as NOP)
//   state_e     sequencer FSM states
//   beat_count  number of byte beats per opcode
//   is_load     opcode returns data into rdata
package mem_seq_pkg;

  localparam int unsigned VEC_BYTES = 8;
  localparam int unsigned BEAT_W    = 3;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_LW  = 3'd1,
    OP_LV  = 3'd2,
    OP_SW  = 3'd3,
    OP_SV  = 3'd4,
    OP_LA  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Beats per request; unused encodings report zero and behave as NOP.
  function automatic logic [3:0] beat_count(input logic [2:0] op);
    case (op)
      OP_LW, OP_SW: beat_count = 4'd1;
      OP_LA:        beat_count = 4'd4;
      OP_LV, OP_SV: beat_count = 4'd8;
      default:      beat_count = 4'd0;
    endcase
  endfunction

  function automatic logic is_load(input logic [2:0] op);
    return (op == OP_LW) || (op == OP_LV) || (op == OP_LA);
  endfunction

endpackage

// File: rtl/byte_lane_assembler.sv
// byte_lane_assembler: 64-bit load assembly register and store-byte mux.
//   clk, rst          clock, async active-low reset
//   clear_i           zero the load register (load accepted)
//   lane_we_i/lane_i  write rbyte_i into byte lane lane_i
//   wdata_load_i      latch wdata_i (request accepted)
//   sel_i             store byte lane to present on store_byte_c
//   rdata_o           assembled load data (registered)
//   store_byte_c      selected store byte (combinational)
module byte_lane_assembler
  import mem_seq_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  input  logic                     lane_we_i,
  input  logic [BEAT_W-1:0]        lane_i,
  input  logic [7:0]               rbyte_i,
  input  logic                     wdata_load_i,
  input  logic [8*VEC_BYTES-1:0]   wdata_i,
  input  logic [BEAT_W-1:0]        sel_i,
  output logic [8*VEC_BYTES-1:0]   rdata_o,
  output logic [7:0]               store_byte_c
);

  logic [8*VEC_BYTES-1:0] rdata_d, rdata_q;
  logic [8*VEC_BYTES-1:0] wdata_d, wdata_q;

  // Clear wins over a lane write; both never coincide in practice.
  always_comb begin
    rdata_d = rdata_q;
    wdata_d = wdata_q;
    if (clear_i) begin
      rdata_d = '0;
    end else if (lane_we_i) begin
      rdata_d[8*lane_i +: 8] = rbyte_i;
    end
    if (wdata_load_i) begin
      wdata_d = wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      wdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
      wdata_q <= wdata_d;
    end
  end

  assign rdata_o      = rdata_q;
  assign store_byte_c = wdata_q[8*sel_i +: 8];

endmodule

// File: rtl/mem_seq_unit.sv
// mem_seq_unit: breaks one load/store request into 1-8 byte beats against an
// 8-bit memory with ready handshake; returns 64-bit load data and a done pulse.
//   clk, rst                     clock, async active-low reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_op/req_addr/req_wdata    request, latched at acceptance
//   rdata, done, err             result, completion pulse, bounds error
//   mem_addr/mem_re/mem_we       beat address and strobes
//   mem_wdata/mem_rdata          byte data
//   mem_ready                    beat completes when high with a strobe
// Build option: MEM_SEQ_BOUNDS_CHECK_EN rejects requests crossing the top of
// memory with err; otherwise addresses wrap and err stays 0.
module mem_seq_unit
  import mem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned VEC_BYTES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_op,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [8*VEC_BYTES-1:0]   req_wdata,
  output logic [8*VEC_BYTES-1:0]   rdata,
  output logic                     done,
  output logic                     err,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_re,
  output logic                     mem_we,
  output logic [7:0]               mem_wdata,
  input  logic [7:0]               mem_rdata,
  input  logic                     mem_ready
);

  state_e              state_d, state_q;
  logic [BEAT_W-1:0]   beat_d, beat_q;
  logic [BEAT_W-1:0]   last_d, last_q;
  logic [ADDR_W-1:0]   mem_addr_d, mem_addr_q;
  logic                mem_re_d, mem_re_q;
  logic                mem_we_d, mem_we_q;
  logic [7:0]          mem_wdata_d, mem_wdata_q;
  logic                done_d, done_q;
  logic                err_d, err_q;
  logic                req_ready_d, req_ready_q;

  logic [3:0]          n_c;
  logic                accept_c;
  logic                clear_c;
  logic                lane_we_c;
  logic [BEAT_W-1:0]   next_beat_c;
  logic [7:0]          store_byte_c;

  assign n_c         = beat_count(req_op);
  assign next_beat_c = beat_q + 3'd1;

`ifdef MEM_SEQ_BOUNDS_CHECK_EN
  // Last beat address computed one bit wider; a carry means it runs off the top.
  localparam int unsigned AW1 = ADDR_W + 1;
  logic [ADDR_W:0] end_addr_c;
  logic            oob_c;
  assign end_addr_c = {1'b0, req_addr} + AW1'(n_c) - AW1'(1);
  assign oob_c      = end_addr_c[ADDR_W];
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    last_d      = last_q;
    mem_addr_d  = mem_addr_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    accept_c    = 1'b0;
    clear_c     = 1'b0;
    lane_we_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          if (n_c == 4'd0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
`ifdef MEM_SEQ_BOUNDS_CHECK_EN
          else if (oob_c) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end
`endif
          else begin
            state_d    = ST_XFER;
            beat_d     = '0;
            last_d     = BEAT_W'(n_c - 4'd1);
            mem_addr_d = req_addr;
            clear_c    = is_load(req_op);
            mem_re_d   = is_load(req_op);
            mem_we_d   = !is_load(req_op);
            if (!is_load(req_op)) begin
              mem_wdata_d = req_wdata[7:0];
            end
          end
        end
      end
      ST_XFER: begin
        // Without mem_ready everything holds, stretching the beat.
        if (mem_ready) begin
          lane_we_c = mem_re_q;
          if (beat_q == last_q) begin
            state_d  = ST_DONE;
            mem_re_d = 1'b0;
            mem_we_d = 1'b0;
            done_d   = 1'b1;
          end else begin
            beat_d     = next_beat_c;
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            if (mem_we_q) begin
              mem_wdata_d = store_byte_c;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      last_q      <= '0;
      mem_addr_q  <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      last_q      <= last_d;
      mem_addr_q  <= mem_addr_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
    end
  end

  byte_lane_assembler u_lanes (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear_c),
    .lane_we_i    (lane_we_c),
    .lane_i       (beat_q),
    .rbyte_i      (mem_rdata),
    .wdata_load_i (accept_c),
    .wdata_i      (req_wdata),
    .sel_i        (next_beat_c),
    .rdata_o      (rdata),
    .store_byte_c (store_byte_c)
  );

  assign req_ready = req_ready_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_seq_unit.md
# mem_seq_unit

Byte-serial main-memory sequencer sitting directly downstream of the 8-bit vector CPU's memory data path. It accepts one word/vector/address load or store request at a time, breaks it into 1–8 byte beats against an 8-bit-wide main memory with a ready handshake, and returns assembled 64-bit load data plus a one-cycle completion pulse. The CPU stalls on `req_ready` low.

## Interface
Parameters:
- `ADDR_W`, 12: main-memory byte address width.
- `VEC_BYTES`, 8: bytes per vector (fixed at 8; data path is 64 bits).

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: high only in IDLE; request accepted when `req_valid & req_ready`.
- `req_op` in 3: 0 NOP, 1 LW, 2 LV, 3 SW, 4 SV, 5 LA; 6–7 treated as NOP.
- `req_addr` in ADDR_W: base byte address.
- `req_wdata` in 64: store data; byte k at `[8k+7:8k]`.
- `rdata` out 64: assembled load data.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: bounds error, valid with `done`.
- `mem_addr` out ADDR_W: beat address.
- `mem_re` out 1: read strobe.
- `mem_we` out 1: write strobe.
- `mem_wdata` out 8: write byte.
- `mem_rdata` in 8: read byte, valid when `mem_ready` high during `mem_re`.
- `mem_ready` in 1: beat completes on a rising edge where strobe and `mem_ready` are both high.

## Operation
- Beat counts: LW 1, SW 1, LA 4, LV 8, SV 8. NOP is accepted and completes with `done` and no strobes.
- Byte order is little-endian. Beat k uses `mem_addr = req_addr + k`. Stores drive `mem_wdata = req_wdata[8k+7:8k]`. Loads write `mem_rdata` into `rdata[8k+7:8k]`.
- Load result:
  - All unfilled bytes of `rdata` are zero. LW is zero-extended from byte 0; LA is zero-extended from bytes 0–3.
  - `rdata` is cleared at acceptance of any load and held until the next accepted load.
  - Stores and NOP do not change `rdata`.
- `req_op`, `req_addr` and `req_wdata` are latched at acceptance. Later changes on these inputs have no effect.
- FSM states:
  - IDLE: `req_ready=1`. Goes to XFER on acceptance, or to DONE for NOP.
  - XFER: exactly one of `mem_re`/`mem_we` is high. The beat counter advances on `mem_ready`. Goes to DONE after the last beat completes.
  - DONE: `done=1` for one cycle, then IDLE.
- Address arithmetic is modulo 2^ADDR_W (wraps 4095→0) unless the bounds-check macro is defined.
- `req_valid` outside IDLE is ignored. No queueing.

## Timing
- Reset values: `req_ready=1`, `rdata=0`, `done=0`, `err=0`, `mem_addr=0`, `mem_re=0`, `mem_we=0`, `mem_wdata=0`, state IDLE, beat counter 0.
- Reset asserted mid-transfer aborts the transfer immediately. No further strobes are issued and no `done` follows.
- Latency with `mem_ready` tied high:
  - Acceptance at edge 0.
  - Beat k strobe is driven in cycle k+1.
  - `done` is high in cycle N+1.
  - `req_ready` returns in cycle N+2.
  - LV therefore takes 10 cycles from acceptance to next acceptance.
- Each `mem_ready`-low cycle extends the current beat by one cycle. The strobe, address and data are held stable during the stall.
- `rdata` is final in the same cycle `done` is high.

## Configuration
- `MEM_SEQ_BOUNDS_CHECK_EN` defined:
  - At acceptance, if `req_addr + N - 1 > 2^ADDR_W - 1`, the unit goes IDLE→DONE with `err=1`.
  - No strobes are issued and `rdata` is unchanged.
- `MEM_SEQ_BOUNDS_CHECK_EN` undefined:
  - Addresses wrap.
  - `err` is tied to 0.

## Structure
- Shared package `mem_seq_pkg` contains:
  - the op encoding enum;
  - the FSM state enum (IDLE, XFER, DONE);
  - the beat-count lookup function;
  - the `VEC_BYTES` constant.
- One sub-module, `byte_lane_assembler`, owns:
  - the clear-on-accept 64-bit load register;
  - byte-lane write enable by beat index;
  - store-byte mux selection.

## Test plan
- LV @0x010, `mem_ready=1`, memory bytes 0x11..0x88 → 8 read beats at 0x010–0x017; `done` in cycle 9; `rdata=64'h8877665544332211`.
- SV @0x100, `wdata=64'hA1B2C3D4E5F60718`, `mem_ready` low on beat 3 for 2 cycles → 0x18 written at 0x100 … 0xA1 written at 0x107; beat 3 strobe held 3 cycles; `done` in cycle 11.
- LW @0x020 after a prior LV → `rdata=64'h00000000000000XX` with XX = byte at 0x020; LA @0x030 → upper 32 bits zero.
- LV @0xFFE:
  - without macro: beats at 0xFFE, 0xFFF, 0x000 … 0x005;
  - with macro: no strobes, `done=1`, `err=1`, `rdata` unchanged.
- Reset asserted during beat 4 of SV → all outputs at reset values asynchronously; no `done`; next LW completes normally.
- `req_valid` held high with changing ops during an LV → ignored; only the latched LV executes; `req_ready` low until cycle 10.
